// File: rtl/teclado_pkg.sv
// Shared definitions for the keypad controller.
// Holds the special key codes, the debounce state type and a small
// key-classification helper used by the entry logic.
package teclado_pkg;

  localparam logic [3:0] K_NONE  = 4'hF;
  localparam logic [3:0] K_CLEAR = 4'hE;
  localparam logic [3:0] K_ENTER = 4'hA;
  localparam logic [3:0] K_BKSP  = 4'hB;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2
  } key_state_t;

  // Numeric keys are the codes 0..9; everything above is a command or idle.
  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/teclado_if.sv
// Keypad controller bus: raw scanner code in, key events and entry value out.
// Signals:
//   key_code    scanner code (4'hF = no key)
//   key_valid   one-cycle pulse per accepted press or repeat
//   key_out     accepted key code, held after the pulse
//   key_held    high from acceptance until release
//   digits      live BCD entry, newest digit in [3:0]
//   digit_count number of digits entered
//   value_valid one-cycle pulse on enter
//   value       digits snapshot taken at enter
//   overflow    sticky, a digit was rejected because the entry was full
// Modports: master = scanner/consumer side, slave = controller side.
interface teclado_if #(
  parameter int NUM_DIGITS = 4
) ();

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);

  logic [3:0]    key_code;
  logic          key_valid;
  logic [3:0]    key_out;
  logic          key_held;
  logic [DW-1:0] digits;
  logic [CW-1:0] digit_count;
  logic          value_valid;
  logic [DW-1:0] value;
  logic          overflow;

  modport master (
    output key_code,
    input  key_valid, key_out, key_held, digits, digit_count,
           value_valid, value, overflow
  );

  modport slave (
    input  key_code,
    output key_valid, key_out, key_held, digits, digit_count,
           value_valid, value, overflow
  );

endinterface

// File: rtl/teclado_key_debounce.sv
// Key debouncer: bridges the column-scan gaps with a presence timer,
// confirms a stable code for DEBOUNCE_CYC cycles and tracks press/release.
// Optional autorepeat is built only when TECLADO_AUTOREPEAT_EN is defined.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   key_code    raw scanner code (4'hF = no key)
//   key_valid   one-cycle pulse on acceptance or repeat
//   key_out     accepted code (4'hF after reset)
//   key_held    high while the accepted key is still present
module key_debounce
  import teclado_pkg::*;
#(
  parameter int PRESENCE_WIN = 22,
  parameter int DEBOUNCE_CYC = 64
`ifdef TECLADO_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 2048,
  parameter int REPEAT_PERIOD = 512
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_code,
  output logic       key_valid,
  output logic [3:0] key_out,
  output logic       key_held
);

  localparam int PCW = $clog2(PRESENCE_WIN + 1);
  localparam int DCW = $clog2(DEBOUNCE_CYC);
  localparam logic [PCW-1:0] PRES_RELOAD = PCW'(PRESENCE_WIN - 1);
  localparam logic [DCW-1:0] DB_LAST     = DCW'(DEBOUNCE_CYC - 1);

  key_state_t     state_r, state_nxt_s;
  logic [PCW-1:0] pres_cnt_r;
  logic [DCW-1:0] db_cnt_r, db_cnt_nxt_s;
  logic [3:0]     cand_r, cand_nxt_s;
  logic           absent_s;
  logic           accept_s;
  logic           rpt_fire_s;
  logic           key_valid_r;
  logic [3:0]     key_out_r;
  logic           key_held_r;

  // Presence timer: any non-idle code reloads it, so the scanner's idle
  // columns between two sightings of the same key do not count as release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pres_cnt_r <= '0;
    end else if (key_code != K_NONE) begin
      pres_cnt_r <= PRES_RELOAD;
    end else if (pres_cnt_r != '0) begin
      pres_cnt_r <= pres_cnt_r - PCW'(1);
    end else begin
      pres_cnt_r <= pres_cnt_r;
    end
  end

  assign absent_s = (pres_cnt_r == '0) && (key_code == K_NONE);

  // Debounce next-state logic; a different code while confirming restarts
  // the count, idle gaps inside the presence window just keep counting.
  always_comb begin
    state_nxt_s  = state_r;
    cand_nxt_s   = cand_r;
    db_cnt_nxt_s = db_cnt_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (key_code != K_NONE) begin
          state_nxt_s  = CONFIRM;
          cand_nxt_s   = key_code;
          db_cnt_nxt_s = '0;
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      CONFIRM: begin
        if (absent_s) begin
          state_nxt_s  = IDLE;
          db_cnt_nxt_s = '0;
        end else if ((key_code != K_NONE) && (key_code != cand_r)) begin
          cand_nxt_s   = key_code;
          db_cnt_nxt_s = '0;
        end else if (db_cnt_r == DB_LAST) begin
          state_nxt_s  = HELD;
          db_cnt_nxt_s = '0;
          accept_s     = 1'b1;
        end else begin
          db_cnt_nxt_s = db_cnt_r + DCW'(1);
        end
      end
      HELD: begin
        if (absent_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HELD;
        end
      end
      default: begin
        state_nxt_s  = IDLE;
        db_cnt_nxt_s = '0;
      end
    endcase
  end

`ifdef TECLADO_AUTOREPEAT_EN
  localparam int RCW = $clog2(REPEAT_DELAY);

  logic [RCW-1:0] rpt_cnt_r, rpt_cnt_nxt_s;

  // Repeat counter: after the first repeat it is rewound by REPEAT_PERIOD so
  // the same terminal compare produces every later repeat.
  always_comb begin
    rpt_cnt_nxt_s = '0;
    rpt_fire_s    = 1'b0;
    if ((state_r == HELD) && !absent_s) begin
      if (rpt_cnt_r == RCW'(REPEAT_DELAY - 1)) begin
        rpt_fire_s    = 1'b1;
        rpt_cnt_nxt_s = RCW'(REPEAT_DELAY - REPEAT_PERIOD);
      end else begin
        rpt_cnt_nxt_s = rpt_cnt_r + RCW'(1);
      end
    end else begin
      rpt_cnt_nxt_s = '0;
    end
  end

  // Repeat counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt_r <= '0;
    end else begin
      rpt_cnt_r <= rpt_cnt_nxt_s;
    end
  end
`else
  assign rpt_fire_s = 1'b0;
`endif

  // FSM state, candidate, debounce count and the registered key outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cand_r      <= K_NONE;
      db_cnt_r    <= '0;
      key_valid_r <= 1'b0;
      key_out_r   <= K_NONE;
      key_held_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cand_r      <= cand_nxt_s;
      db_cnt_r    <= db_cnt_nxt_s;
      key_valid_r <= accept_s | rpt_fire_s;
      key_out_r   <= accept_s ? cand_r : key_out_r;
      key_held_r  <= (state_nxt_s == HELD);
    end
  end

  assign key_valid = key_valid_r;
  assign key_out   = key_out_r;
  assign key_held  = key_held_r;

endmodule

// File: rtl/teclado_ctrl.sv
// Keypad controller top: debounced key events feed a BCD number-entry
// register with clear (E), enter (A) and backspace (B).
// Optional autorepeat: define TECLADO_AUTOREPEAT_EN.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         teclado_if slave: key_code in; key_valid, key_out, key_held,
//               digits, digit_count, value_valid, value, overflow out
module teclado_ctrl
  import teclado_pkg::*;
#(
  parameter int SCAN_DIV     = 5,
  parameter int PRESENCE_WIN = 4 * SCAN_DIV + 2,
  parameter int DEBOUNCE_CYC = 64,
  parameter int NUM_DIGITS   = 4
`ifdef TECLADO_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 2048,
  parameter int REPEAT_PERIOD = 512
`endif
) (
  input  logic     clk,
  input  logic     rst_n,
  teclado_if.slave bus
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NUM_DIGITS);

  logic          kv_s;
  logic [3:0]    kout_s;
  logic          kheld_s;
  logic [DW-1:0] digits_r, digits_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic          ovf_r, ovf_nxt_s;
  logic [DW-1:0] value_r, value_nxt_s;
  logic          vv_r, vv_nxt_s;

  key_debounce #(
    .PRESENCE_WIN (PRESENCE_WIN),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
`ifdef TECLADO_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_code (bus.key_code),
    .key_valid(kv_s),
    .key_out  (kout_s),
    .key_held (kheld_s)
  );

  // Entry next-state: acts on the registered key pulse, so every update is
  // visible the cycle after key_valid.
  always_comb begin
    digits_nxt_s = digits_r;
    cnt_nxt_s    = cnt_r;
    ovf_nxt_s    = ovf_r;
    value_nxt_s  = value_r;
    vv_nxt_s     = 1'b0;
    if (kv_s) begin
      if (is_digit(kout_s)) begin
        if (cnt_r < CNT_FULL) begin
          digits_nxt_s = {digits_r[DW-5:0], kout_s};
          cnt_nxt_s    = cnt_r + CW'(1);
        end else begin
          ovf_nxt_s    = 1'b1;
        end
      end else begin
        case (kout_s)
          K_BKSP: begin
            if (cnt_r != '0) begin
              digits_nxt_s = {4'h0, digits_r[DW-1:4]};
              cnt_nxt_s    = cnt_r - CW'(1);
            end else begin
              cnt_nxt_s    = cnt_r;
            end
          end
          K_CLEAR: begin
            digits_nxt_s = '0;
            cnt_nxt_s    = '0;
            ovf_nxt_s    = 1'b0;
          end
          K_ENTER: begin
            value_nxt_s  = digits_r;
            vv_nxt_s     = 1'b1;
            digits_nxt_s = '0;
            cnt_nxt_s    = '0;
            ovf_nxt_s    = 1'b0;
          end
          default: begin
            // C and D are reported as events but leave the entry alone.
            vv_nxt_s = 1'b0;
          end
        endcase
      end
    end else begin
      vv_nxt_s = 1'b0;
    end
  end

  // Entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_r <= '0;
      cnt_r    <= '0;
      ovf_r    <= 1'b0;
      value_r  <= '0;
      vv_r     <= 1'b0;
    end else begin
      digits_r <= digits_nxt_s;
      cnt_r    <= cnt_nxt_s;
      ovf_r    <= ovf_nxt_s;
      value_r  <= value_nxt_s;
      vv_r     <= vv_nxt_s;
    end
  end

  assign bus.key_valid   = kv_s;
  assign bus.key_out     = kout_s;
  assign bus.key_held    = kheld_s;
  assign bus.digits      = digits_r;
  assign bus.digit_count = cnt_r;
  assign bus.value_valid = vv_r;
  assign bus.value       = value_r;
  assign bus.overflow    = ovf_r;

endmodule

// File: tb/tb_teclado_ctrl.sv
// Self-checking bench for teclado_ctrl: a time-stamp based reference model
// checked every cycle, a table of key presses with expected entry state,
// hand-written corner sequences and randomized scanner-like stimulus.
module tb_teclado_ctrl;
  import teclado_pkg::*;

  localparam int SD = 5;
  localparam int PW = 4 * SD + 2;
  localparam int DC = 64;
  localparam int ND = 4;
`ifdef TECLADO_AUTOREPEAT_EN
  localparam int RD = 2048;
  localparam int RP = 512;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cur_key = 4'hF;

  always #5 clk = ~clk;

  teclado_if #(.NUM_DIGITS(ND)) bus ();
  assign bus.key_code = cur_key;

  teclado_ctrl #(
    .SCAN_DIV(SD), .PRESENCE_WIN(PW), .DEBOUNCE_CYC(DC), .NUM_DIGITS(ND)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model state (time stamps, not counters)
  int         t;
  int         last_seen;
  bit         m_confirm, m_held, m_kv, m_vv, m_ovf, pend;
  logic [3:0] m_cand, m_kout, pend_key;
  int         m_since, m_accept_t;
  logic [3:0] q[$];
  logic [15:0] m_value;

  int step_no, kv_seen, vv_seen, kv_first;

  typedef struct {
    logic [3:0]  key;
    logic [15:0] digits;
    int          count;
    bit          ovf;
    logic [15:0] value;
    int          vv;
  } row_t;
  row_t tbl[14];

  function automatic logic [15:0] pack();
    logic [15:0] r = 16'h0;
    foreach (q[i]) r = {r[11:0], q[i]};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    last_seen = -100000;
    m_confirm = 0; m_held = 0; m_kv = 0; m_vv = 0; m_ovf = 0; pend = 0;
    m_kout = 4'hF; m_cand = 4'hF;
    q.delete();
    m_value = 16'h0;
  endtask

  task automatic apply_key(input logic [3:0] k);
    if (k <= 4'd9) begin
      if (q.size() < ND) q.push_back(k);
      else m_ovf = 1;
    end else if (k == 4'hB) begin
      if (q.size() > 0) void'(q.pop_back());
    end else if (k == 4'hE) begin
      q.delete(); m_ovf = 0;
    end else if (k == 4'hA) begin
      m_value = pack(); m_vv = 1; q.delete(); m_ovf = 0;
    end
  endtask

  task automatic model_edge(input logic [3:0] k);
    bit absent;
    m_vv = 0;
    if (pend) apply_key(pend_key);
    pend = 0;
    m_kv = 0;
    absent = (k == 4'hF) && (t - last_seen >= PW);
    if (k != 4'hF) last_seen = t;
    if (m_held) begin
      if (absent) m_held = 0;
`ifdef TECLADO_AUTOREPEAT_EN
      else if ((t - m_accept_t) >= RD && ((t - m_accept_t - RD) % RP) == 0) m_kv = 1;
`endif
    end else if (m_confirm) begin
      if (absent) m_confirm = 0;
      else if (k != 4'hF && k != m_cand) begin m_cand = k; m_since = t; end
      else if (t - m_since == DC) begin
        m_confirm = 0; m_held = 1; m_kout = m_cand; m_accept_t = t; m_kv = 1;
      end
    end else if (k != 4'hF) begin
      m_confirm = 1; m_cand = k; m_since = t;
    end
    if (m_kv) begin pend = 1; pend_key = m_kout; end
    t++;
  endtask

  task automatic step();
    logic [15:0] ed;
    @(posedge clk);
    model_edge(cur_key);
    #1;
    step_no++;
    if (bus.key_valid) begin
      kv_seen++;
      if (kv_first < 0) kv_first = step_no;
    end
    if (bus.value_valid) vv_seen++;
    ed = pack();
    checks++;
    if (bus.key_valid !== m_kv || bus.key_out !== m_kout || bus.key_held !== m_held ||
        bus.digits !== ed || int'(bus.digit_count) != q.size() || bus.value_valid !== m_vv ||
        bus.value !== m_value || bus.overflow !== m_ovf) begin
      errors++;
      $display("FAIL model t=%0d got kv=%b ko=%h h=%b d=%h n=%0d vv=%b v=%h o=%b expected kv=%b ko=%h h=%b d=%h n=%0d vv=%b v=%h o=%b",
               t, bus.key_valid, bus.key_out, bus.key_held, bus.digits, bus.digit_count,
               bus.value_valid, bus.value, bus.overflow, m_kv, m_kout, m_held, ed, q.size(),
               m_vv, m_value, m_ovf);
    end
  endtask

  task automatic run(input logic [3:0] k, input int n);
    cur_key = k;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input logic [3:0] k);
    run(k, DC + 8);
    run(4'hF, PW + 6);
  endtask

  task automatic clr_counts();
    step_no = 0; kv_seen = 0; vv_seen = 0; kv_first = -1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_kv"},   bus.key_valid, 0);
    chk({tag, "_kout"}, bus.key_out, 32'hF);
    chk({tag, "_held"}, bus.key_held, 0);
    chk({tag, "_dig"},  bus.digits, 0);
    chk({tag, "_cnt"},  bus.digit_count, 0);
    chk({tag, "_vv"},   bus.value_valid, 0);
    chk({tag, "_val"},  bus.value, 0);
    chk({tag, "_ovf"},  bus.overflow, 0);
  endtask

  initial begin
    tbl[0]  = '{4'hE, 16'h0000, 0, 0, 16'h0000, 0};
    tbl[1]  = '{4'h1, 16'h0001, 1, 0, 16'h0000, 0};
    tbl[2]  = '{4'h2, 16'h0012, 2, 0, 16'h0000, 0};
    tbl[3]  = '{4'h3, 16'h0123, 3, 0, 16'h0000, 0};
    tbl[4]  = '{4'h4, 16'h1234, 4, 0, 16'h0000, 0};
    tbl[5]  = '{4'h5, 16'h1234, 4, 1, 16'h0000, 0};
    tbl[6]  = '{4'hA, 16'h0000, 0, 0, 16'h1234, 1};
    tbl[7]  = '{4'h7, 16'h0007, 1, 0, 16'h1234, 0};
    tbl[8]  = '{4'h8, 16'h0078, 2, 0, 16'h1234, 0};
    tbl[9]  = '{4'hB, 16'h0007, 1, 0, 16'h1234, 0};
    tbl[10] = '{4'h9, 16'h0079, 2, 0, 16'h1234, 0};
    tbl[11] = '{4'hE, 16'h0000, 0, 0, 16'h1234, 0};
    tbl[12] = '{4'hC, 16'h0000, 0, 0, 16'h1234, 0};
    tbl[13] = '{4'hA, 16'h0000, 0, 0, 16'h0000, 1};

    t = 0;
    model_reset();
    clr_counts();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // scanner bursts of 5 every 20 cycles, then idle
    clr_counts();
    for (int b = 0; b < 10; b++) begin
      run(4'h5, SD);
      run(4'hF, 3 * SD);
    end
    run(4'hF, PW);
    chk("burst_pulses", kv_seen, 1);
    chk("burst_latency", kv_first, DC + 1);
    chk("burst_released", bus.key_held, 0);
    chk("burst_digits", bus.digits, 16'h0005);

    // too short to be accepted
    clr_counts();
    run(4'h3, 30);
    run(4'hF, PW + 4);
    chk("short_pulses", kv_seen, 0);
    chk("short_digits", bus.digits, 16'h0005);

    // table of presses and the entry state after each
    foreach (tbl[i]) begin
      clr_counts();
      press(tbl[i].key);
      chk($sformatf("tbl%0d_kv", i), kv_seen, 1);
      chk($sformatf("tbl%0d_vv", i), vv_seen, tbl[i].vv);
      chk($sformatf("tbl%0d_dig", i), bus.digits, tbl[i].digits);
      chk($sformatf("tbl%0d_cnt", i), bus.digit_count, tbl[i].count);
      chk($sformatf("tbl%0d_ovf", i), bus.overflow, tbl[i].ovf);
      chk($sformatf("tbl%0d_val", i), bus.value, tbl[i].value);
    end

    // long hold of 6
    clr_counts();
`ifdef TECLADO_AUTOREPEAT_EN
    // release timed so the presence window closes before a fifth pulse
    run(4'h6, DC + RD + 3 * RP - PW - 2);
    run(4'hF, PW + 6);
    chk("hold_pulses", kv_seen, 4);
    chk("hold_digits", bus.digits, 16'h6666);
`else
    run(4'h6, DC + 2048 + 3 * 512);
    run(4'hF, PW + 6);
    chk("hold_pulses", kv_seen, 1);
    chk("hold_digits", bus.digits, 16'h0006);
`endif
    press(4'hE);

    // reset in the middle of confirming a key with a partial entry
    press(4'h1);
    press(4'h2);
    chk("pre_rst_digits", bus.digits, 16'h0012);
    run(4'h7, 20);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mid");
    cur_key = 4'hF;
    repeat (3) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clr_counts();
    run(4'hF, DC + 10);
    chk("post_rst_pulses", kv_seen, 0);

    // randomized presses: continuous, scanner bursts, or with glitches
    for (int r = 0; r < 40; r++) begin
      logic [3:0] k;
      int mode, len, ph;
      k    = 4'($urandom_range(0, 14));
      mode = $urandom_range(0, 2);
      len  = $urandom_range(5, 160);
      ph   = $urandom_range(0, 4 * SD - 1);
      for (int i = 0; i < len; i++) begin
        if (mode == 0) cur_key = k;
        else if (mode == 1) cur_key = (((i + ph) % (4 * SD)) < SD) ? k : 4'hF;
        else cur_key = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : k;
        step();
      end
      run(4'hF, $urandom_range(0, 2 * PW));
    end
    run(4'hF, PW + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
